// File: rtl/taxi_sfp_port_ctrl.sv
// taxi_sfp_port_ctrl: per-port SFP+ bring-up sequencer with a shared ms prescaler,
// per-port ms timers and a debounced link-up state machine.
module taxi_sfp_port_ctrl #(
    parameter int CNT      = 2,
    parameter int TICK_CYC = 125000,
    parameter int INIT_MS  = 300,
    parameter int LINK_MS  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT-1:0]     sfp_npres,
    input  logic [CNT-1:0]     sfp_los,
    input  logic [CNT-1:0]     rx_status,
    input  logic [CNT-1:0]     cfg_enable,
    input  logic [CNT-1:0]     cfg_rs,
    output logic [CNT-1:0]     sfp_tx_disable,
    output logic [CNT-1:0]     sfp_rs,
    output logic [CNT-1:0]     mac_rx_rst,
    output logic [CNT-1:0]     link_up,
    output logic [CNT-1:0]     sfp_led,
    output logic [CNT*3-1:0]   port_state,
    output logic [CNT*8-1:0]   link_down_cnt
);
    localparam int MAX_MS = INIT_MS > LINK_MS ? INIT_MS : LINK_MS;
    localparam int TW     = MAX_MS > 0 ? $clog2(MAX_MS + 1) : 1;
    localparam int PW     = TICK_CYC > 1 ? $clog2(TICK_CYC) : 1;

    typedef enum logic [2:0] {
        ABSENT    = 3'd0,
        INIT      = 3'd1,
        WAIT_SIG  = 3'd2,
        LINK_WAIT = 3'd3,
        UP        = 3'd4
    } state_t;

    logic [CNT-1:0] npres_m, npres_s, los_m, los_s, rx_m, rx_s;
    logic [PW-1:0]  pre;
    logic           tick;

    assign tick = pre == PW'(TICK_CYC - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {npres_m, npres_s, los_m, los_s, rx_m, rx_s} <= '0;
            pre    <= '0;
            sfp_rs <= '0;
        end else begin
            {npres_s, los_s, rx_s} <= {npres_m, los_m, rx_m};
            {npres_m, los_m, rx_m} <= {sfp_npres, sfp_los, rx_status};
            pre    <= tick ? '0 : pre + 1'b1;
            sfp_rs <= cfg_rs;
        end
    end

    for (genvar i = 0; i < CNT; i++) begin : g_port
        state_t        state, state_n;
        logic [TW-1:0] tmr, tmr_n;
        logic [7:0]    down_cnt, down_cnt_q;
        logic [2:0]    state_q;
        logic          expired, entry, entry_q, exit_up, txd_q, up_q, mrr_q;

        assign expired = tmr == '0;

        // Absence/disable overrides everything; LINK_WAIT restarts its window on any rx_status drop.
        always_comb begin
            state_n = state;
            tmr_n   = (tick && !expired) ? tmr - 1'b1 : tmr;
            entry   = 1'b0;
            exit_up = 1'b0;
            if (npres_s[i] || !cfg_enable[i]) begin
                state_n = ABSENT;
            end else begin
                case (state)
                    ABSENT: begin
                        state_n = INIT;
                        tmr_n   = TW'(INIT_MS);
                    end
                    INIT: state_n = expired ? WAIT_SIG : INIT;
                    WAIT_SIG: if (!los_s[i]) begin
                        state_n = LINK_WAIT;
                        tmr_n   = TW'(LINK_MS);
                        entry   = 1'b1;
                    end
                    LINK_WAIT: begin
                        if (los_s[i]) state_n = WAIT_SIG;
                        else if (!rx_s[i]) tmr_n = TW'(LINK_MS);
                        else if (expired) state_n = UP;
                    end
                    UP: if (los_s[i] || !rx_s[i]) begin
                        state_n = WAIT_SIG;
                        exit_up = 1'b1;
                    end
                    default: state_n = ABSENT;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state      <= ABSENT;
                tmr        <= '0;
                down_cnt   <= '0;
                entry_q    <= 1'b0;
                txd_q      <= 1'b1;
                up_q       <= 1'b0;
                mrr_q      <= 1'b0;
                state_q    <= '0;
                down_cnt_q <= '0;
            end else begin
                state      <= state_n;
                tmr        <= tmr_n;
                entry_q    <= entry;
                if (exit_up && down_cnt != 8'hff) down_cnt <= down_cnt + 1'b1;
                txd_q      <= state == ABSENT || state == INIT;
                up_q       <= state == UP;
                mrr_q      <= entry_q;
                state_q    <= state;
                down_cnt_q <= down_cnt;
            end
        end

        assign sfp_tx_disable[i]      = txd_q;
        assign link_up[i]             = up_q;
        assign sfp_led[i]             = up_q;
        assign mac_rx_rst[i]          = mrr_q;
        assign port_state[i*3 +: 3]   = state_q;
        assign link_down_cnt[i*8 +: 8] = down_cnt_q;
    end
endmodule

// File: tb/tb_taxi_sfp_port_ctrl.sv
// tb_taxi_sfp_port_ctrl: table vectors, directed corner sequences and random stimulus
// checked cycle by cycle against a behavioural model of the port rules.
module tb_taxi_sfp_port_ctrl;
    localparam int CNT = 2, TICK = 10, INIT_MS = 3, LINK_MS = 2;
    localparam int ST_ABSENT = 0, ST_INIT = 1, ST_WAIT_SIG = 2, ST_LINK_WAIT = 3, ST_UP = 4;
    localparam logic [31:0] RESET_OUT = 32'hC000_0000;

    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] npres = '0, los = '0, rx = '1, en = '1, rs = '0;
    logic [1:0] sfp_tx_disable, sfp_rs, mac_rx_rst, link_up, sfp_led;
    logic [5:0] port_state;
    logic [15:0] link_down_cnt;

    always #5 clk = ~clk;

    taxi_sfp_port_ctrl #(.CNT(CNT), .TICK_CYC(TICK), .INIT_MS(INIT_MS), .LINK_MS(LINK_MS)) dut (
        .clk(clk), .rst(rst), .sfp_npres(npres), .sfp_los(los), .rx_status(rx),
        .cfg_enable(en), .cfg_rs(rs), .sfp_tx_disable(sfp_tx_disable), .sfp_rs(sfp_rs),
        .mac_rx_rst(mac_rx_rst), .link_up(link_up), .sfp_led(sfp_led),
        .port_state(port_state), .link_down_cnt(link_down_cnt)
    );

    int n_chk = 0, n_fail = 0;

    // model: input pipelines, ms counter, per-port phase, remaining ms, UP exits, pending rx reset
    int m_pre;
    logic [1:0] np1, np2, los1, los2, rx1, rx2;
    int m_st[2], m_ms[2], m_down[2];
    bit m_pend[2];
    logic [1:0] e_txd, e_rs, e_mrr, e_up, e_led;
    logic [5:0] e_ps;
    logic [15:0] e_cnt;

    typedef struct {
        logic [1:0] npres, los, rx, en, rs;
        int cyc;
        logic [5:0] ps;
        logic [1:0] txd, up;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [31:0] dut_out();
        return {sfp_tx_disable, sfp_rs, mac_rx_rst, link_up, sfp_led, port_state, link_down_cnt};
    endfunction

    function automatic logic [31:0] exp_out();
        return {e_txd, e_rs, e_mrr, e_up, e_led, e_ps, e_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_pre = 0;
        {np1, np2, los1, los2, rx1, rx2} = '0;
        for (int p = 0; p < 2; p++) begin
            m_st[p] = ST_ABSENT; m_ms[p] = 0; m_down[p] = 0; m_pend[p] = 0;
        end
        e_txd = '1; {e_rs, e_mrr, e_up, e_led, e_ps, e_cnt} = '0;
    endtask

    task automatic model_step();
        bit tick;
        for (int p = 0; p < 2; p++) begin
            e_txd[p] = m_st[p] < ST_WAIT_SIG;
            e_up[p] = m_st[p] == ST_UP;
            e_led[p] = m_st[p] == ST_UP;
            e_mrr[p] = m_pend[p];
            e_ps[p*3 +: 3] = 3'(m_st[p]);
            e_cnt[p*8 +: 8] = 8'(m_down[p]);
        end
        e_rs = rs;
        tick = m_pre == TICK - 1;
        m_pre = tick ? 0 : m_pre + 1;
        for (int p = 0; p < 2; p++) begin
            int ms;
            ms = (tick && m_ms[p] > 0) ? m_ms[p] - 1 : m_ms[p];
            m_pend[p] = 0;
            if (np2[p] || !en[p]) m_st[p] = ST_ABSENT;
            else if (m_st[p] == ST_ABSENT) begin m_st[p] = ST_INIT; ms = INIT_MS; end
            else if (m_st[p] == ST_INIT) begin if (m_ms[p] == 0) m_st[p] = ST_WAIT_SIG; end
            else if (m_st[p] == ST_WAIT_SIG) begin
                if (!los2[p]) begin m_st[p] = ST_LINK_WAIT; ms = LINK_MS; m_pend[p] = 1; end
            end else if (m_st[p] == ST_LINK_WAIT) begin
                if (los2[p]) m_st[p] = ST_WAIT_SIG;
                else if (!rx2[p]) ms = LINK_MS;
                else if (m_ms[p] == 0) m_st[p] = ST_UP;
            end else if (los2[p] || !rx2[p]) begin
                m_st[p] = ST_WAIT_SIG;
                m_down[p] = m_down[p] < 255 ? m_down[p] + 1 : 255;
            end
            m_ms[p] = ms;
        end
        np2 = np1; np1 = npres; los2 = los1; los1 = los; rx2 = rx1; rx1 = rx;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        check("outputs", dut_out(), exp_out());
    endtask

    task automatic bringup(input string tag);
        int n_dis = 0, n_mrr = 0, drop_at = 0, up_at = 0;
        for (int i = 1; i <= 80; i++) begin
            cycle();
            if (sfp_tx_disable[0]) n_dis++;
            if (mac_rx_rst[0]) n_mrr++;
            if (!sfp_tx_disable[0] && drop_at == 0) drop_at = i;
            if (link_up[0] && up_at == 0) up_at = i;
        end
        check_range({tag, "_init_holdoff"}, n_dis, 30, 40);
        check({tag, "_mac_rx_rst_pulses"}, 32'(n_mrr), 32'd1);
        check_range({tag, "_link_wait_len"}, up_at - drop_at, 11, 22);
        check({tag, "_link_up"}, 32'(link_up), 32'h3);
        check({tag, "_down_cnt"}, 32'(link_down_cnt[7:0]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, pulses;
        bit ok;
        tbl[0] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 5,  6'o44, 2'b00, 2'b11};
        tbl[1] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b10, 5,  6'o42, 2'b00, 2'b10};
        tbl[2] = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 5,  6'o43, 2'b00, 2'b10};
        tbl[3] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 40, 6'o44, 2'b00, 2'b11};
        tbl[4] = '{2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 4,  6'o40, 2'b01, 2'b10};
        tbl[5] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 5,  6'o41, 2'b01, 2'b10};
        tbl[6] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b01, 60, 6'o44, 2'b00, 2'b11};
        tbl[7] = '{2'b01, 2'b00, 2'b11, 2'b11, 2'b10, 5,  6'o40, 2'b01, 2'b10};
        tbl[8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 40, 6'o22, 2'b00, 2'b00};
        tbl[9] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 40, 6'o44, 2'b00, 2'b11};
        model_reset();
        rs = 2'b01;
        repeat (2) @(negedge clk);
        check("reset_state", dut_out(), RESET_OUT);
        rst = 1'b0;
        bringup("powerup");

        foreach (tbl[k]) begin
            {npres, los, rx, en, rs} = {tbl[k].npres, tbl[k].los, tbl[k].rx, tbl[k].en, tbl[k].rs};
            repeat (tbl[k].cyc) cycle();
            check($sformatf("tbl%0d_state", k), 32'(port_state), 32'(tbl[k].ps));
            check($sformatf("tbl%0d_txdis", k), 32'(sfp_tx_disable), 32'(tbl[k].txd));
            check($sformatf("tbl%0d_up", k), 32'(link_up), 32'(tbl[k].up));
            check($sformatf("tbl%0d_rs", k), 32'(sfp_rs), 32'(tbl[k].rs));
        end

        // rx_status glitch mid LINK_WAIT restarts the 2 ms window
        los = 2'b01;
        repeat (4) cycle();
        los = 2'b00;
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin cycle(); ok = port_state[2:0] == 3'd3; end
        check("flap_reach_link_wait", 32'(ok), 32'd1);
        repeat (5) cycle();
        rx = 2'b10;
        cycle();
        rx = 2'b11;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin cycle(); if (port_state[2:0] == 3'd4) n = i; end
        check_range("flap_up_delay", n, 15, 24);

        // repeated link loss saturates the down counter
        pulses = 0;
        ok = 1;
        for (int t = 0; t < 300 && ok; t++) begin
            los = 2'b01;
            repeat (4) begin cycle(); if (mac_rx_rst[0]) pulses++; end
            los = 2'b00;
            for (int k = 0; k < 50 && !e_up[0]; k++) begin cycle(); if (mac_rx_rst[0]) pulses++; end
            ok = e_up[0];
        end
        check("loss_relink_bound", 32'(ok), 32'd1);
        check("loss_mac_rx_rst_pulses", 32'(pulses), 32'd300);
        check("loss_down_cnt_sat", 32'(link_down_cnt[7:0]), 32'd255);

        // hot removal coinciding with los
        npres = 2'b01;
        los = 2'b01;
        ok = 0;
        repeat (5) begin cycle(); if (port_state[2:0] == 3'd2) ok = 1; end
        check("removal_no_wait_sig", 32'(ok), 32'd0);
        check("removal_state0", 32'(port_state[2:0]), 32'd0);
        check("removal_txdis0", 32'(sfp_tx_disable[0]), 32'd1);
        check("removal_up0", 32'(link_up[0]), 32'd0);
        check("removal_state1", 32'(port_state[5:3]), 32'd4);

        // async reset while UP
        npres = 2'b00;
        los = 2'b00;
        for (int k = 0; k < 100 && e_up != 2'b11; k++) cycle();
        check("pre_reset_up", 32'(link_up), 32'h3);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", dut_out(), RESET_OUT);
        cycle();
        rst = 1'b0;
        bringup("after_reset");

        for (int s = 0; s < 150; s++) begin
            npres = {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0};
            los = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            rx = {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0};
            en = {$urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0};
            rs = 2'($urandom);
            repeat ($urandom_range(1, 30)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/taxi_sfp_port_ctrl.md
TAXI_SFP_PORT_CTRL -- requirements
Module: taxi_sfp_port_ctrl

Interface
REQ-001 SHALL have parameter CNT, default 2: number of SFP+ ports managed.
REQ-002 SHALL have parameter TICK_CYC, default 125000: clk cycles per 1 ms tick (125 MHz).
REQ-003 SHALL have parameter INIT_MS, default 300: module init hold-off with tx_disable asserted, in ms.
REQ-004 SHALL have parameter LINK_MS, default 10: rx_status stable time before link declared up, in ms.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock. All logic runs on it.
- rst  in  1  reset, asynchronous, active-high.
- sfp_npres  in  CNT  module not-present pin, asynchronous.
- sfp_los  in  CNT  loss-of-signal pin, asynchronous.
- rx_status  in  CNT  MAC per-lane RX status, from the rx_clk domain.
- cfg_enable  in  CNT  per-port enable.
- cfg_rs  in  CNT  per-port rate-select value.
- sfp_tx_disable  out  CNT  laser disable.
- sfp_rs  out  CNT  rate select.
- mac_rx_rst  out  CNT  one-cycle MAC RX reset request.
- link_up  out  CNT  port in UP state.
- sfp_led  out  CNT  link LED.
- port_state  out  CNT x 3  current state encoding.
- link_down_cnt  out  CNT x 8  saturating count of UP exits.

Function
REQ-006 SHALL pass each of sfp_npres, sfp_los and rx_status through a 2-flop synchronizer before use; all later references in this document mean the synchronized values.
REQ-007 SHALL contain one shared ms prescaler.
- It counts 0..TICK_CYC-1 and pulses tick for one cycle at wrap.
- It runs continuously after reset.
REQ-008 SHALL contain one ms timer per port, wide enough to hold max(INIT_MS, LINK_MS).
- Loads occur on the state entries named below.
- The timer decrements on tick while nonzero.
- The timer is "expired" when it is zero.
REQ-009 SHALL implement a per-port state machine with the following states:
- ABSENT=0: tx_disable=1.
- INIT=1: tx_disable=1.
- WAIT_SIG=2: tx_disable=0.
- LINK_WAIT=3: tx_disable=0.
- UP=4: tx_disable=0, link_up=1, led=1.
REQ-010 SHALL apply an override in every state: npres=1 or cfg_enable=0 forces ABSENT on the next cycle. This override has priority over all other transitions.
REQ-011 ABSENT transitions: npres=0 and cfg_enable=1 -> INIT, and the timer loads INIT_MS.
REQ-012 INIT transitions: timer expired -> WAIT_SIG.
REQ-013 WAIT_SIG transitions: los=0 -> LINK_WAIT.
- The timer loads LINK_MS.
- mac_rx_rst pulses high for exactly one cycle on entry.
REQ-014 LINK_WAIT transitions, in priority order:
- los=1 -> WAIT_SIG.
- else rx_status=0 -> reload LINK_MS and stay.
- else timer expired -> UP.
REQ-015 UP transitions: los=1 or rx_status=0 -> WAIT_SIG, and link_down_cnt increments, saturating at 255.
REQ-016 SHALL register all outputs as Moore outputs, valid in the cycle after the state register updates. sfp_rs SHALL equal the registered cfg_rs, with no state dependency.
REQ-017 SHALL update ports independently. Simultaneous events on different ports SHALL not interact, apart from sharing tick.
REQ-018 SHALL resolve a timer expiry and an los change in the same cycle in favour of the los transition.
REQ-019 SHALL accept an INIT_MS change with no effect until the next ABSENT->INIT entry.
- Parameters are static.
- The timer is only reloaded on the entries stated above.

Reset
REQ-020 On rst SHALL set:
- all states to ABSENT;
- sfp_tx_disable='1;
- sfp_rs='0;
- mac_rx_rst='0, link_up='0, sfp_led='0;
- port_state=0, link_down_cnt=0;
- prescaler=0, timers=0;
- synchronizer flops=0.
REQ-021 A reset asserted mid-operation, including in UP, SHALL take effect immediately and asynchronously on all outputs. Release SHALL resume from ABSENT.

Verification
Scenarios use TICK_CYC=10, INIT_MS=3, LINK_MS=2, CNT=2.
REQ-022 Power-up bring-up:
- Stimulus: npres[0]=0, cfg_enable=2'b11, los=0, rx_status=1.
- tx_disable[0] stays 1 through INIT (30-40 cycles).
- It then drops, with mac_rx_rst[0] high for exactly 1 cycle.
- link_up[0]=1 after 2 further ticks.
- link_down_cnt[0]=0.
REQ-023 rx_status flaps in LINK_WAIT:
- Stimulus: rx_status[0] pulsed low 1 cycle mid-wait.
- The timer reloads to 2.
- UP is reached 2 full ticks after the glitch, not before.
REQ-024 Link loss and saturation:
- Stimulus: los[0] toggled 1/0 300 times while in UP.
- Each toggle returns the port to WAIT_SIG then LINK_WAIT, with one mac_rx_rst pulse per entry.
- link_down_cnt[0] ends at 255.
REQ-025 Hot removal:
- Stimulus: npres[0]=1 while in UP, same cycle as los[0]=1.
- The port goes to ABSENT, not WAIT_SIG.
- tx_disable[0]=1 and link_up[0]=0.
- Port 1's state is unaffected.
REQ-026 Async reset in UP:
- Stimulus: rst asserted mid-cycle.
- Outputs go to reset values before the next clk edge.
- After release the INIT hold-off repeats in full.
